// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, reset PC, enable levels,
// NOP encoding, stall-vector bit positions and the PC-generator states.
package inst_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_BUS_W  = 32;

    localparam logic [INST_ADDR_W-1:0] ZERO_WORD    = '0;
    localparam logic [INST_ADDR_W-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [INST_BUS_W-1:0]  NOP_INST     = '0;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam int STALL_PC_BIT = 0;
    localparam int STALL_IF_BIT = 1;
    localparam int STALL_ID_BIT = 2;
    localparam int STALL_W      = 3;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_pc_gen.sv
// PC register and BOOT/RUN/HOLD sequencer; drives the ROM chip enable
// and byte address straight from the PC.
module inst_fetch_pc_gen
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_pc,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic              run,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr
);

    fetch_state_t state;
    logic         ce_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
            pc    <= RESET_PC;
            ce_q  <= CHIP_DISABLE;
        end else begin
            unique case (state)
                BOOT: begin
                    // First edge only arms the ROM; the PC is not consumed yet.
                    state <= RUN;
                    ce_q  <= CHIP_ENABLE;
                end
                default: begin
                    if (flush) begin
                        state <= RUN;
                        pc    <= new_pc;
                    end else if (stall_pc) begin
                        state <= HOLD;
                    end else begin
                        state <= RUN;
                        pc    <= branch_flag ? branch_target
                                             : pc + ADDR_W'(4);
                    end
                end
            endcase
        end
    end

    assign run      = ce_q;
    assign rom_ce   = ce_q & (pc[1:0] == 2'b00);
    assign rom_addr = pc;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC generation plus the IF/ID pipeline
// register, with stall, delay-slot branch, flush and AdEL tagging.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int          ADDR_W   = INST_ADDR_W,
    parameter int          INST_W   = INST_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_pc,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_valid,
    output logic              id_adel
);

    logic [STALL_W-1:0] stall;
    logic [ADDR_W-1:0]  pc;
    logic               run;
    logic               misaligned;
    logic               bubble;

    assign stall = {stall_id, stall_if, stall_pc};

    inst_fetch_pc_gen #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (ADDR_W'(RESET_PC))
    ) u_pc_gen (
        .clk           (clk),
        .rst           (rst),
        .stall_pc      (stall[STALL_PC_BIT]),
        .flush         (flush),
        .new_pc        (new_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .pc            (pc),
        .run           (run),
        .rom_ce        (rom_ce),
        .rom_addr      (rom_addr)
    );

    assign misaligned = pc[1:0] != 2'b00;

    // IF stalled while ID drains: insert a bubble rather than duplicate.
    assign bubble = flush
                  | (stall[STALL_IF_BIT] & ~stall[STALL_ID_BIT])
                  | (~stall[STALL_IF_BIT] & ~run);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc    <= '0;
            id_inst  <= NOP_INST[INST_W-1:0];
            id_valid <= 1'b0;
            id_adel  <= 1'b0;
        end else if (bubble) begin
            id_pc    <= '0;
            id_inst  <= NOP_INST[INST_W-1:0];
            id_valid <= 1'b0;
            id_adel  <= 1'b0;
        end else if (!stall[STALL_IF_BIT]) begin
            id_pc    <= pc;
            id_inst  <= misaligned ? NOP_INST[INST_W-1:0] : rom_inst;
            id_valid <= 1'b1;
            id_adel  <= misaligned;
        end
    end

endmodule
